controller_reader: RTL and testbench
====================================

CONTROLLER_READER -- requirements
Module: controller_reader

Interface
REQ-001 Parameter HALF_PERIOD, default 76, cycles per half pulse period (about 6 us at 12.5875 MHz); legal range 4..255.
REQ-002 clk  input  1  system clock, 12.5875 MHz.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start_fetch  input  1  GPU fetch request, high for 10 cycles at frame start; only its 0->1 edge is significant.
REQ-005 ctrl_latch  output  1  latch strobe to both controllers, active-high.
REQ-006 ctrl_pulse  output  1  shift clock to both controllers, active-high.
REQ-007 ctrl_data_1, ctrl_data_2  input  1 each  serial button data, active-low (0 = pressed), asynchronous to clk.
REQ-008 SELECT_controller_1, SELECT_controller_2  input  1 each  CPU read selects.
REQ-009 data_out  output  8  CPU read bus; high-impedance when no select is active.
REQ-010 buttons_1, buttons_2  output  8 each  registered button state, active-high; bit0 A, bit1 B, bit2 Select, bit3 Start, bit4 Up, bit5 Down, bit6 Left, bit7 Right.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 ctrl_data_1 and ctrl_data_2 shall each pass through a two-flop synchronizer; all sampling uses the synchronized values.
REQ-013 start_prev register; a fetch triggers when start_fetch=1 and start_prev=0, with the FSM in IDLE.
REQ-014 FSM states: IDLE, LATCH, LOW, HIGH, DONE; a 9-bit phase counter cnt and a 3-bit bit index idx.
REQ-015 IDLE: latch=0 and pulse=0; on a trigger, enter LATCH with cnt=0.
REQ-016 LATCH: latch=1 for 2*HALF_PERIOD cycles.
  - On the last cycle, sample bit 0 into the shadow registers, set idx=1 and enter LOW.
REQ-017 LOW: pulse=0 and latch=0 for HALF_PERIOD cycles, then enter HIGH.
REQ-018 HIGH: pulse=1 for HALF_PERIOD cycles.
  - On the last cycle, sample bit idx.
  - If idx=7, enter DONE; otherwise increment idx and enter LOW.
REQ-019 Sampling: shadow_n[i] = ~synchronized ctrl_data_n.
REQ-020 DONE lasts one cycle: copy shadow_1 to buttons_1 and shadow_2 to buttons_2 in the same cycle, then enter IDLE.
  - buttons_n never shows a partial frame.
REQ-021 Fetch duration is 16*HALF_PERIOD+1 cycles from LATCH entry to IDLE re-entry (1217 cycles at the default HALF_PERIOD).
REQ-022 A start_fetch edge while busy=1 shall be ignored, not queued.
REQ-023 ctrl_latch and ctrl_pulse shall be driven from registers (glitch-free) and shall never be high simultaneously.
REQ-024 data_out: SELECT_controller_1 gives buttons_1; otherwise SELECT_controller_2 gives buttons_2; otherwise 8'bz.
  - If both selects are high, controller 1 wins.
  - The read path is combinational; a read in the DONE cycle returns the pre-update value.

Reset
REQ-025 rst sets: FSM=IDLE, cnt=0, idx=0, ctrl_latch=0, ctrl_pulse=0, shadows=0, buttons_1=buttons_2=0, busy=0, synchronizer flops=1, start_prev=1.
REQ-026 rst mid-fetch shall abort immediately; buttons_n are cleared and no partial result is published.
REQ-027 Because start_prev resets to 1, start_fetch held high through reset shall not trigger a fetch; the first 0->1 edge after reset does.

Structure
REQ-028 A shared package controller_pkg holds the FSM state enum, the HALF_PERIOD default and the button bit-index constants.
REQ-029 One sub-module, sync_2ff (1-bit two-flop synchronizer, reset value 1), instantiated once per controller.

Verification (bench HALF_PERIOD=4)
REQ-030 Single fetch: rst, then start_fetch 0->1 held 10 cycles, both data lines driven by a model presenting 8'hA5 pressed.
  - Required: buttons_1=buttons_2=8'hA5 exactly 65 cycles after LATCH entry.
  - Required: latch high 8 cycles, 7 pulses of 4 cycles high.
REQ-031 Idle lines: both data lines held 1 for the whole fetch -> buttons=8'h00; data lines held 0 -> buttons=8'hFF.
REQ-032 Re-trigger while busy: a second start_fetch edge at cycle 20 of a fetch.
  - Required: no restart; the fetch completes at cycle 65; exactly one LATCH pulse.
REQ-033 Reset mid-fetch: rst at cycle 30 with the prior value buttons_1=8'h3C.
  - Required: next cycle latch=0, pulse=0, busy=0, buttons_1=8'h00; the next edge runs a full fetch.
REQ-034 Read bus: buttons_1=8'h12, buttons_2=8'h34.
  - SEL1 -> 8'h12; SEL2 -> 8'h34; both -> 8'h12; neither -> 8'bz.
REQ-035 Reset with start_fetch high: hold start_fetch=1 through rst deassertion -> no fetch (busy stays 0); drop to 0 then raise -> fetch starts.

Source files
------------

// File: rtl/controller_reader_pkg.sv
// Shared definitions for the controller reader: FSM states, timing default
// and the bit position of every button in the published button bytes.
package controller_pkg;

  // Cycles per half pulse period (~6 us at 12.5875 MHz).
  localparam int HALF_PERIOD_DEFAULT = 76;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Bit order of the serial stream; also the bit index in buttons_n.
  typedef enum logic [2:0] {
    BTN_A      = 3'd0,
    BTN_B      = 3'd1,
    BTN_SELECT = 3'd2,
    BTN_START  = 3'd3,
    BTN_UP     = 3'd4,
    BTN_DOWN   = 3'd5,
    BTN_LEFT   = 3'd6,
    BTN_RIGHT  = 3'd7
  } btn_idx_e;

endpackage

// File: rtl/controller_reader_if.sv
// Pin bundle between the controller reader, the two game controllers,
// the GPU fetch request and the CPU-visible button state.
interface controller_reader_if;
  logic       start_fetch;
  logic       ctrl_latch;
  logic       ctrl_pulse;
  logic       ctrl_data_1;
  logic       ctrl_data_2;
  logic       SELECT_controller_1;
  logic       SELECT_controller_2;
  logic [7:0] buttons_1;
  logic [7:0] buttons_2;
  logic       busy;

  // Reader side.
  modport slave (
    input  start_fetch,
    input  ctrl_data_1,
    input  ctrl_data_2,
    input  SELECT_controller_1,
    input  SELECT_controller_2,
    output ctrl_latch,
    output ctrl_pulse,
    output buttons_1,
    output buttons_2,
    output busy
  );

  // System side (controllers, GPU, CPU).
  modport master (
    output start_fetch,
    output ctrl_data_1,
    output ctrl_data_2,
    output SELECT_controller_1,
    output SELECT_controller_2,
    input  ctrl_latch,
    input  ctrl_pulse,
    input  buttons_1,
    input  buttons_2,
    input  busy
  );
endinterface

// File: rtl/controller_reader_sync_2ff.sv
// Two-flop synchronizer for one asynchronous controller data line.
// Resets to 1, the idle (released) level of the serial data line.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values simply shift the input down the two-flop chain.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/controller_reader.sv
// Reads two serial game controllers once per frame: latch, then eight
// sampled bits clocked by a pulse train; the captured frame is published
// atomically to buttons_1/2, which the CPU reads over a tristate bus.
module controller_reader
  import controller_pkg::*;
#(
  parameter int HALF_PERIOD = HALF_PERIOD_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  controller_reader_if.slave bus,
  // Tristate read bus; kept as a plain port so the high-impedance state
  // does not have to travel through the interface.
  output wire  [7:0]         data_out
);
  localparam logic [8:0] HALF_LAST  = 9'(HALF_PERIOD - 1);
  localparam logic [8:0] LATCH_LAST = 9'(2 * HALF_PERIOD - 1);

  logic data_1_s;
  logic data_2_s;

  sync_2ff u_sync_1 (
    .clk (clk),
    .rst (rst),
    .d   (bus.ctrl_data_1),
    .q   (data_1_s)
  );

  sync_2ff u_sync_2 (
    .clk (clk),
    .rst (rst),
    .d   (bus.ctrl_data_2),
    .q   (data_2_s)
  );

  state_e     state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic       latch_q, latch_d;
  logic       pulse_q, pulse_d;
  logic       busy_q, busy_d;
  logic       start_prev_q, start_prev_d;
  logic [7:0] shadow_1_q, shadow_1_d;
  logic [7:0] shadow_2_q, shadow_2_d;
  logic [7:0] buttons_1_q, buttons_1_d;
  logic [7:0] buttons_2_q, buttons_2_d;
  logic       trigger;

  // Fetch sequencer: next state, phase counter, bit index, strobes and
  // shadow/published button bytes. Strobes are computed one cycle ahead so
  // the registered versions line up exactly with the state they belong to.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    latch_d      = latch_q;
    pulse_d      = pulse_q;
    shadow_1_d   = shadow_1_q;
    shadow_2_d   = shadow_2_q;
    buttons_1_d  = buttons_1_q;
    buttons_2_d  = buttons_2_q;
    start_prev_d = bus.start_fetch;
    trigger      = bus.start_fetch & ~start_prev_q;

    case (state_q)
      ST_IDLE: begin
        latch_d = 1'b0;
        pulse_d = 1'b0;
        if (trigger) begin
          state_d = ST_LATCH;
          cnt_d   = 9'd0;
          latch_d = 1'b1;
        end
      end

      ST_LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          // Latch released: bit 0 (A) is already on the data line.
          shadow_1_d[BTN_A] = ~data_1_s;
          shadow_2_d[BTN_A] = ~data_2_s;
          idx_d   = 3'd1;
          cnt_d   = 9'd0;
          latch_d = 1'b0;
          state_d = ST_LOW;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      ST_LOW: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = 9'd0;
          pulse_d = 1'b1;
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      ST_HIGH: begin
        if (cnt_q == HALF_LAST) begin
          // Sample late in the high phase so the shifted bit has had time
          // to cross the synchronizer.
          shadow_1_d[idx_q] = ~data_1_s;
          shadow_2_d[idx_q] = ~data_2_s;
          cnt_d   = 9'd0;
          pulse_d = 1'b0;
          if (idx_q == BTN_RIGHT) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_LOW;
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      ST_DONE: begin
        // Publish both frames in one cycle so readers never see a mix.
        buttons_1_d = shadow_1_q;
        buttons_2_d = shadow_2_q;
        idx_d       = 3'd0;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        latch_d = 1'b0;
        pulse_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any fetch in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 9'd0;
      idx_q        <= 3'd0;
      latch_q      <= 1'b0;
      pulse_q      <= 1'b0;
      busy_q       <= 1'b0;
      start_prev_q <= 1'b1;
      shadow_1_q   <= 8'h00;
      shadow_2_q   <= 8'h00;
      buttons_1_q  <= 8'h00;
      buttons_2_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      latch_q      <= latch_d;
      pulse_q      <= pulse_d;
      busy_q       <= busy_d;
      start_prev_q <= start_prev_d;
      shadow_1_q   <= shadow_1_d;
      shadow_2_q   <= shadow_2_d;
      buttons_1_q  <= buttons_1_d;
      buttons_2_q  <= buttons_2_d;
    end
  end

  assign bus.ctrl_latch = latch_q;
  assign bus.ctrl_pulse = pulse_q;
  assign bus.busy       = busy_q;
  assign bus.buttons_1  = buttons_1_q;
  assign bus.buttons_2  = buttons_2_q;

  // Controller 1 has priority when both selects are asserted.
  assign data_out = bus.SELECT_controller_1 ? buttons_1_q :
                    bus.SELECT_controller_2 ? buttons_2_q : 8'bzzzzzzzz;
endmodule

// File: tb/tb_controller_reader.sv
// Bench for controller_reader at HALF_PERIOD=4: a pair of serial controller
// models, a timeline model of the fetch, and directed scenarios.
module tb_controller_reader;
  import controller_pkg::*;

  localparam int H = 4;

  logic clk;
  logic rst;
  wire  [7:0] data_out;

  controller_reader_if ifc ();

  controller_reader #(.HALF_PERIOD(H)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (ifc),
    .data_out (data_out)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  logic chk_en = 1'b0;

  // Controller stimulus: mode 0 = shift register holding pat, 1 = line held 1, 2 = line held 0
  logic [7:0] pat1 = 8'h00;
  logic [7:0] pat2 = 8'h00;
  int mode1 = 0;
  int mode2 = 0;

  // Fetch timeline model
  bit         m_active = 1'b0;
  int         m_k      = 0;
  bit         m_prev   = 1'b1;
  logic [7:0] m_b1     = 8'h00;
  logic [7:0] m_b2     = 8'h00;
  logic [7:0] m_p1     = 8'h00;
  logic [7:0] m_p2     = 8'h00;

  // Activity monitor
  int latch_rises = 0, pulse_rises = 0, latch_hi = 0, pulse_hi = 0;
  int last_latch_rise = 0, last_btn_chg = 0;
  logic l_prev = 1'b0, p_prev = 1'b0;
  logic [7:0] b1_prev = 8'h00, b2_prev = 8'h00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [7:0] frame_of(input int mode, input logic [7:0] p);
    if (mode == 1) return 8'h00;
    if (mode == 2) return 8'hFF;
    return p;
  endfunction

  function automatic logic line_of(input int mode, input logic [7:0] p, input int pos);
    if (mode == 1) return 1'b1;
    if (mode == 2) return 1'b0;
    if (pos > 7) return 1'b1;
    return ~p[pos];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Two controllers sharing latch/pulse: latch reloads, each pulse rise shifts.
  initial begin
    int   pos;
    logic pp;
    pos = 0;
    pp  = 1'b0;
    ifc.ctrl_data_1 = 1'b1;
    ifc.ctrl_data_2 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ifc.ctrl_latch) pos = 0;
      else if (ifc.ctrl_pulse && !pp) pos++;
      pp = ifc.ctrl_pulse;
      ifc.ctrl_data_1 = line_of(mode1, pat1, pos);
      ifc.ctrl_data_2 = line_of(mode2, pat2, pos);
    end
  end

  // Per-cycle compare against the timeline model, then monitor, then advance model.
  initial forever begin
    logic e_latch, e_pulse;
    @(negedge clk);
    e_latch = m_active && (m_k < 2*H);
    e_pulse = m_active && (m_k >= 2*H) && (m_k < 16*H) && ((((m_k - 2*H) / H) % 2) == 1);
    if (chk_en) begin
      check("latch", ifc.ctrl_latch, e_latch);
      check("pulse", ifc.ctrl_pulse, e_pulse);
      check("busy", ifc.busy, m_active);
      check("buttons_1", ifc.buttons_1, m_b1);
      check("buttons_2", ifc.buttons_2, m_b2);
      if (ifc.SELECT_controller_1) check("data_out_sel1", data_out, m_b1);
      else if (ifc.SELECT_controller_2) check("data_out_sel2", data_out, m_b2);
    end

    if (ifc.ctrl_latch === 1'b1) latch_hi++;
    if (ifc.ctrl_pulse === 1'b1) pulse_hi++;
    if (ifc.ctrl_latch === 1'b1 && l_prev !== 1'b1) begin
      latch_rises++;
      last_latch_rise = cyc;
    end
    if (ifc.ctrl_pulse === 1'b1 && p_prev !== 1'b1) pulse_rises++;
    if (ifc.buttons_1 !== b1_prev || ifc.buttons_2 !== b2_prev) last_btn_chg = cyc;
    l_prev  = ifc.ctrl_latch;
    p_prev  = ifc.ctrl_pulse;
    b1_prev = ifc.buttons_1;
    b2_prev = ifc.buttons_2;

    if (rst) begin
      m_active = 1'b0;
      m_k      = 0;
      m_prev   = 1'b1;
      m_b1     = 8'h00;
      m_b2     = 8'h00;
    end else begin
      if (m_active) begin
        if (m_k == 16*H) begin
          m_active = 1'b0;
          m_b1     = m_p1;
          m_b2     = m_p2;
        end else begin
          m_k++;
        end
      end else if (ifc.start_fetch && !m_prev) begin
        m_active = 1'b1;
        m_k      = 0;
        m_p1     = frame_of(mode1, pat1);
        m_p2     = frame_of(mode2, pat2);
      end
      m_prev = ifc.start_fetch;
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (ifc.busy && n < 300) begin
      tick(1);
      n++;
    end
    check({name, "_timeout"}, ifc.busy, 1'b0);
    tick(2);
  endtask

  // Full fetch with activity/latency checks against hand-derived numbers.
  task automatic run_fetch(input string name, input logic [7:0] e1, input logic [7:0] e2);
    int lr0, pr0, lh0, ph0;
    lr0 = latch_rises; pr0 = pulse_rises; lh0 = latch_hi; ph0 = pulse_hi;
    ifc.start_fetch = 1'b1;
    tick(10);
    ifc.start_fetch = 1'b0;
    wait_idle(name);
    check({name, "_latch_cycles"}, latch_hi - lh0, 8);
    check({name, "_latch_count"}, latch_rises - lr0, 1);
    check({name, "_pulse_count"}, pulse_rises - pr0, 7);
    check({name, "_pulse_cycles"}, pulse_hi - ph0, 28);
    check({name, "_latency"}, last_btn_chg - last_latch_rise, 65);
    check({name, "_b1"}, ifc.buttons_1, e1);
    check({name, "_b2"}, ifc.buttons_2, e2);
  endtask

  initial begin
    int lr0;
    rst = 1'b1;
    ifc.start_fetch = 1'b0;
    ifc.SELECT_controller_1 = 1'b0;
    ifc.SELECT_controller_2 = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    tick(2);
    check("rst_busy", ifc.busy, 1'b0);
    check("rst_latch", ifc.ctrl_latch, 1'b0);
    check("rst_pulse", ifc.ctrl_pulse, 1'b0);
    check("rst_b1", ifc.buttons_1, 8'h00);
    check("rst_b2", ifc.buttons_2, 8'h00);
    rst = 1'b0;
    tick(3);

    // Single fetch, A5 pressed on both controllers
    pat1 = 8'hA5; pat2 = 8'hA5; mode1 = 0; mode2 = 0;
    run_fetch("single", 8'hA5, 8'hA5);

    // Idle lines
    mode1 = 1; mode2 = 1;
    run_fetch("idle_hi", 8'h00, 8'h00);
    mode1 = 2; mode2 = 2;
    run_fetch("idle_lo", 8'hFF, 8'hFF);

    // Re-trigger while busy: second edge at fetch cycle 20
    mode1 = 0; mode2 = 0; pat1 = 8'h5A; pat2 = 8'h5A;
    lr0 = latch_rises;
    ifc.start_fetch = 1'b1;
    tick(10);
    ifc.start_fetch = 1'b0;
    tick(10);
    ifc.start_fetch = 1'b1;
    tick(5);
    ifc.start_fetch = 1'b0;
    wait_idle("retrig");
    check("retrig_latch_count", latch_rises - lr0, 1);
    check("retrig_latency", last_btn_chg - last_latch_rise, 65);
    check("retrig_b1", ifc.buttons_1, 8'h5A);

    // Reset mid-fetch with buttons_1 = 3C beforehand
    pat1 = 8'h3C; pat2 = 8'h3C;
    run_fetch("pre_rst", 8'h3C, 8'h3C);
    pat1 = 8'hC3; pat2 = 8'hC3;
    ifc.start_fetch = 1'b1;
    tick(10);
    ifc.start_fetch = 1'b0;
    tick(20);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("abort_latch", ifc.ctrl_latch, 1'b0);
    check("abort_pulse", ifc.ctrl_pulse, 1'b0);
    check("abort_busy", ifc.busy, 1'b0);
    check("abort_b1", ifc.buttons_1, 8'h00);
    tick(2);
    run_fetch("post_rst", 8'hC3, 8'hC3);

    // Read bus; SEL1 held through the fetch covers the DONE-cycle read
    pat1 = 8'h12; pat2 = 8'h34;
    ifc.SELECT_controller_1 = 1'b1;
    run_fetch("rd_fetch", 8'h12, 8'h34);
    ifc.SELECT_controller_1 = 1'b1; ifc.SELECT_controller_2 = 1'b0;
    tick(1);
    check("rd_sel1", data_out, 8'h12);
    ifc.SELECT_controller_1 = 1'b0; ifc.SELECT_controller_2 = 1'b1;
    tick(1);
    check("rd_sel2", data_out, 8'h34);
    ifc.SELECT_controller_1 = 1'b1; ifc.SELECT_controller_2 = 1'b1;
    tick(1);
    check("rd_both", data_out, 8'h12);
    ifc.SELECT_controller_1 = 1'b0; ifc.SELECT_controller_2 = 1'b0;
    tick(1);
    n_chk++;
    if (data_out === 8'bzzzzzzzz) n_pass++;
    else $display("FAIL rd_none: got %b expected zzzzzzzz", data_out);

    // start_fetch held high through reset must not trigger
    ifc.start_fetch = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    lr0 = latch_rises;
    tick(10);
    check("hold_busy", ifc.busy, 1'b0);
    check("hold_latch_count", latch_rises - lr0, 0);
    ifc.start_fetch = 1'b0;
    tick(2);
    ifc.start_fetch = 1'b1;
    tick(2);
    check("hold_edge_busy", ifc.busy, 1'b1);
    check("hold_edge_latch", ifc.ctrl_latch, 1'b1);
    tick(8);
    ifc.start_fetch = 1'b0;
    wait_idle("hold_fetch");
    check("hold_fetch_b1", ifc.buttons_1, 8'h12);
    check("hold_fetch_b2", ifc.buttons_2, 8'h34);

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
